// File: rtl/seq_mult_engine.sv
// seq_mult_engine: sequential shift-add multiplier with start/busy/done handshake.
// Produces a full 2W-bit product in signed or unsigned mode and stops early
// once the multiplier has no set bits left.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           begin an operation (accepted in IDLE or DONE only)
//   signed_mode     1 = two's-complement operands (sampled with start)
//   operand_a/b     multiplicand / multiplier (sampled with start)
//   result          low W bits of the product
//   result_hi       high W bits of the product
//   overflow        product does not fit in W bits for the latched mode
//   busy            high in RUN and FINISH
//   done            high in DONE
//   iterations      RUN cycles used by the last operation
module seq_mult_engine #(
    parameter int BIT_WIDTH = 16,
    parameter int CNT_WIDTH = $clog2(BIT_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [BIT_WIDTH-1:0] operand_a,
    input  logic [BIT_WIDTH-1:0] operand_b,
    output logic [BIT_WIDTH-1:0] result,
    output logic [BIT_WIDTH-1:0] result_hi,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] iterations
);
    localparam int W = BIT_WIDTH;
    localparam int P = 2 * BIT_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

    state_t               state_q, state_d;
    logic [P-1:0]         acc_q, mcand_q;
    logic [W-1:0]         mplier_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 neg_q, signed_q;

    logic [W-1:0]         mag_a, mag_b;
    logic                 neg_in, load;
    logic [W-1:0]         mplier_shr;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [P-1:0]         product;
    logic                 ovf_calc;

    // Magnitudes fit in W unsigned bits, so -2^(W-1) maps to 2^(W-1) exactly.
    always_comb begin
        mag_a  = operand_a;
        mag_b  = operand_b;
        neg_in = 1'b0;
        if (signed_mode) begin
            if (operand_a[W-1]) mag_a = ~operand_a + 1'b1;
            if (operand_b[W-1]) mag_b = ~operand_b + 1'b1;
            neg_in = operand_a[W-1] ^ operand_b[W-1];
        end
    end

    assign load       = start && (state_q == IDLE || state_q == DONE);
    assign mplier_shr = mplier_q >> 1;
    assign cnt_nxt    = cnt_q + 1'b1;

    // Sign applied once at the end on the unsigned accumulator.
    always_comb begin
        product = neg_q ? (~acc_q + 1'b1) : acc_q;
        if (signed_q)
            ovf_calc = !((&product[P-1:W-1]) || !(|product[P-1:W-1]));
        else
            ovf_calc = |product[P-1:W];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start)
                    state_d = (mag_a == '0 || mag_b == '0) ? FINISH : RUN;
            end
            RUN: begin
                // Stop as soon as no multiplier bits remain.
                if (mplier_shr == '0 || cnt_nxt == CNT_WIDTH'(W))
                    state_d = FINISH;
            end
            FINISH:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            signed_q   <= 1'b0;
            result     <= '0;
            result_hi  <= '0;
            overflow   <= 1'b0;
            iterations <= '0;
        end else begin
            if (load) begin
                acc_q    <= '0;
                mcand_q  <= {{W{1'b0}}, mag_a};
                mplier_q <= mag_b;
                cnt_q    <= '0;
                neg_q    <= neg_in;
                signed_q <= signed_mode;
            end else if (state_q == RUN) begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_shr;
                cnt_q    <= cnt_nxt;
            end else if (state_q == FINISH) begin
                result     <= product[W-1:0];
                result_hi  <= product[P-1:W];
                overflow   <= ovf_calc;
                iterations <= cnt_q;
            end
        end
    end

    assign busy = (state_q == RUN) || (state_q == FINISH);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_mult_engine.sv
module tb_seq_mult_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [15:0] operand_a = '0;
    logic [15:0] operand_b = '0;
    logic [15:0] result, result_hi;
    logic        overflow, busy, done;
    logic [4:0]  iterations;

    int tests = 0;
    int fails = 0;

    seq_mult_engine #(.BIT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .operand_a(operand_a), .operand_b(operand_b),
        .result(result), .result_hi(result_hi), .overflow(overflow),
        .busy(busy), .done(done), .iterations(iterations)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        ovf;
        logic [4:0]  it;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer multiply on the interpreted operands.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sm,
                                  output logic [15:0] lo, output logic [15:0] hi,
                                  output logic ovf, output logic [4:0] it);
        longint sa, sb, p, ma, mb;
        logic [31:0] pp;
        int n;
        sa = sm ? longint'($signed(a)) : longint'(a);
        sb = sm ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        pp = p[31:0];
        lo = pp[15:0];
        hi = pp[31:16];
        ovf = sm ? (p < -32768 || p > 32767) : (p > 65535);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        n = 0;
        if (ma != 0 && mb != 0)
            while ((mb >> n) != 0) n++;
        it = 5'(n);
    endfunction

    // Called at a negedge. E0 counts as edge 1, so the required latency is it+2.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input logic [15:0] lo, input logic [15:0] hi,
                          input logic ovf, input logic [4:0] it);
        int edges;
        operand_a = a; operand_b = b; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        operand_a = 16'hDEAD; operand_b = 16'hBEEF; signed_mode = ~sm;
        chk({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        chk({tag, " done_dropped"}, {31'd0, done}, 32'd0);
        while (!done && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (busy && done) chk({tag, " busy_done_exclusive"}, 32'd1, 32'd0);
        end
        chk({tag, " latency"}, 32'(edges), 32'(it) + 32'd2);
        chk({tag, " result"}, {16'd0, result}, {16'd0, lo});
        chk({tag, " result_hi"}, {16'd0, result_hi}, {16'd0, hi});
        chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, ovf});
        chk({tag, " iterations"}, {27'd0, iterations}, {27'd0, it});
        chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, " result"}, {16'd0, result}, 32'd0);
        chk({tag, " result_hi"}, {16'd0, result_hi}, 32'd0);
        chk({tag, " overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, " iterations"}, {27'd0, iterations}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb, lo, hi;
        logic        rs, ovf;
        logic [4:0]  it;
        int          edges;

        vecs[0]  = '{16'd3,     16'd5,     1'b0, 16'd15,    16'h0000, 1'b0, 5'd3};
        vecs[1]  = '{16'd7,     16'd8,     1'b0, 16'd56,    16'h0000, 1'b0, 5'd4};
        vecs[2]  = '{16'd255,   16'd255,   1'b0, 16'd65025, 16'h0000, 1'b0, 5'd8};
        vecs[3]  = '{16'd0,     16'd5,     1'b0, 16'd0,     16'h0000, 1'b0, 5'd0};
        vecs[4]  = '{16'd5,     16'd0,     1'b0, 16'd0,     16'h0000, 1'b0, 5'd0};
        vecs[5]  = '{16'd1,     16'd42,    1'b0, 16'd42,    16'h0000, 1'b0, 5'd6};
        vecs[6]  = '{16'd42,    16'd1,     1'b0, 16'd42,    16'h0000, 1'b0, 5'd1};
        vecs[7]  = '{16'hFFFF,  16'hFFFF,  1'b0, 16'h0001,  16'hFFFE, 1'b1, 5'd16};
        vecs[8]  = '{16'hFFFD,  16'd5,     1'b1, 16'hFFF1,  16'hFFFF, 1'b0, 5'd3};
        vecs[9]  = '{16'h8000,  16'hFFFF,  1'b1, 16'h8000,  16'h0000, 1'b1, 5'd1};
        vecs[10] = '{16'd100,   16'hFFFE,  1'b1, 16'hFF38,  16'hFFFF, 1'b0, 5'd2};
        vecs[11] = '{16'h8000,  16'h8000,  1'b1, 16'h0000,  16'h4000, 1'b1, 5'd16};
        vecs[12] = '{16'hFFFF,  16'd0,     1'b1, 16'h0000,  16'h0000, 1'b0, 5'd0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset");

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm,
                   vecs[i].lo, vecs[i].hi, vecs[i].ovf, vecs[i].it);

        // Randomized operations against the model, back to back from DONE.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: begin ra = 16'($urandom_range(0, 20)); rb = 16'($urandom_range(0, 20)); end
                1: begin ra = 16'($urandom); rb = 16'($urandom_range(0, 255)); end
                default: begin ra = 16'($urandom); rb = 16'($urandom); end
            endcase
            rs = 1'($urandom);
            model(ra, rb, rs, lo, hi, ovf, it);
            run_op($sformatf("rand%0d", n), ra, rb, rs, lo, hi, ovf, it);
        end

        // 12*10 with a start pulse during RUN that must be ignored.
        operand_a = 16'd12; operand_b = 16'd10; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        operand_a = 16'd9; operand_b = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        while (!done && edges < 40) begin @(negedge clk); edges++; end
        chk("busy_start done", {31'd0, done}, 32'd1);
        chk("busy_start result", {16'd0, result}, 32'd120);
        chk("busy_start iterations", {27'd0, iterations}, 32'd4);
        // Restart straight from DONE.
        operand_a = 16'd2; operand_b = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart done_drop", {31'd0, done}, 32'd0);
        chk("restart busy", {31'd0, busy}, 32'd1);
        chk("restart result_held", {16'd0, result}, 32'd120);
        edges = 0;
        while (!done && edges < 40) begin @(negedge clk); edges++; end
        chk("restart result", {16'd0, result}, 32'd4);
        chk("restart iterations", {27'd0, iterations}, 32'd2);

        // Reset in the middle of RUN.
        operand_a = 16'd255; operand_b = 16'd255; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrun busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("midrun_rst");
        repeat (12) @(negedge clk);
        check_idle_zero("midrun_rst_later");

        // Reset and start on the same edge.
        operand_a = 16'd3; operand_b = 16'd5; rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_idle_zero("rst_start");
        repeat (6) @(negedge clk);
        check_idle_zero("rst_start_later");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
